// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_seq_pkg
//  Description : Shared types and helpers for the PLL reset sequencer.
//                - pll_seq_state_e : sequencer state encoding (3-bit)
//                - cnt_width()     : width of the shared down-counter
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // State names carry an ST_ prefix so they cannot collide with the
    // sequencer's timing parameters (e.g. SETTLE).
    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_seq_state_e;

    // The counter is only ever loaded with (N - 1) for the largest N, so
    // $clog2(N) bits suffice; never return less than one bit.
    function automatic int cnt_width(input int rst_pulse,
                                     input int lock_timeout,
                                     input int settle);
        int m;
        m = rst_pulse;
        if (lock_timeout > m) m = lock_timeout;
        if (settle > m)       m = settle;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage : pll_seq_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for asynchronous level/status inputs.
//                Reset value of both stages is 0.
//  Ports       : clk   - destination clock
//                rst   - synchronous active-high reset
//                d_i   - asynchronous input bus (bits treated independently)
//                q_o   - synchronized output, 2 clk edges of latency
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : Brings up the system PLL from the reference clock domain:
//                pulses the PLL reset, waits for lock (with timeout and
//                bounded retries), requires lock to stay stable for a settle
//                window, then releases the core reset. Lock loss while
//                running restarts the whole sequence.
//  Ports       : refclk       - reference clock, sole clock
//                rst          - synchronous active-high reset
//                pll_locked_i - PLL lock, asynchronous to refclk
//                soft_req_i   - one-cycle restart request
//                pll_rst_o    - PLL reset (active-high, registered)
//                core_rst_o   - core reset (active-high, registered)
//                fail_o       - retries exhausted
//                retries_o    - timeouts since last clean start (sat. 3)
//                loss_cnt_o   - lock-loss events in RUN (sat. 255)
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int SETTLE       = 1024,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked_i,
    input  logic       soft_req_i,
    output logic       pll_rst_o,
    output logic       core_rst_o,
    output logic       fail_o,
    output logic [1:0] retries_o,
    output logic [7:0] loss_cnt_o
);

    localparam int CW = cnt_width(RST_PULSE, LOCK_TIMEOUT, SETTLE);

    localparam logic [CW-1:0] c_hold_load   = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] c_wait_load   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] c_settle_load = CW'(SETTLE - 1);

    pll_seq_state_e state_q;
    logic [CW-1:0]  cnt_q;
    logic           pll_rst_q;
    logic           core_rst_q;
    logic           fail_q;
    logic [1:0]     retries_q;
    logic [7:0]     loss_q;

    logic           w_lk;
    logic [1:0]     w_retries_inc;
    logic [7:0]     w_loss_inc;
    logic           w_retry_exhausted;

    // ------------------------------------------------------------------
    // Lock synchronizer: every decision below uses w_lk only.
    // ------------------------------------------------------------------
    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked_i),
        .q_o (w_lk)
    );

    assign w_retries_inc     = (retries_q == 2'd3) ? retries_q : retries_q + 2'd1;
    assign w_loss_inc        = (loss_q == 8'hFF)   ? loss_q    : loss_q + 8'd1;
    // Decision is taken on the post-increment value.
    assign w_retry_exhausted = (int'(w_retries_inc) >= MAX_RETRIES);

    // ------------------------------------------------------------------
    // Sequencer FSM. Outputs are updated on the same edge as the state
    // they belong to, so they are always registered and consistent.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            cnt_q      <= c_hold_load;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            fail_q     <= 1'b0;
            retries_q  <= 2'd0;
            loss_q     <= 8'd0;
        end else if (soft_req_i) begin
            // Full restart; lock-loss history is intentionally preserved.
            state_q    <= ST_HOLD;
            cnt_q      <= c_hold_load;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            fail_q     <= 1'b0;
            retries_q  <= 2'd0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q   <= ST_WAIT_LOCK;
                        cnt_q     <= c_wait_load;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock takes precedence over a coincident timeout.
                    if (w_lk) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= c_settle_load;
                    end else if (cnt_q == '0) begin
                        retries_q <= w_retries_inc;
                        if (w_retry_exhausted) begin
                            state_q <= ST_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_HOLD;
                            cnt_q     <= c_hold_load;
                            pll_rst_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_SETTLE: begin
                    // A dropout here is a glitch: wait again, no retry charged.
                    if (!w_lk) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= c_wait_load;
                    end else if (cnt_q == '0) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!w_lk) begin
                        state_q    <= ST_HOLD;
                        cnt_q      <= c_hold_load;
                        pll_rst_q  <= 1'b1;
                        core_rst_q <= 1'b1;
                        loss_q     <= w_loss_inc;
                        retries_q  <= 2'd0;
                    end
                end

                ST_FAIL: begin
                    // Parked until soft_req_i or rst.
                end

                default: begin
                    state_q    <= ST_HOLD;
                    cnt_q      <= c_hold_load;
                    pll_rst_q  <= 1'b1;
                    core_rst_q <= 1'b1;
                    fail_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o  = pll_rst_q;
    assign core_rst_o = core_rst_q;
    assign fail_o     = fail_q;
    assign retries_o  = retries_q;
    assign loss_cnt_o = loss_q;

endmodule : pll_reset_sequencer
`default_nettype wire
